// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div32_seq
//  Purpose  : Iterative unsigned restoring divider. Each RUN cycle performs
//             one trial subtraction and produces one quotient bit. A
//             start/done handshake lets the control unit drive it as the
//             ALU's multi-cycle DIV/MOD unit.
//  Revision : 1.0  initial release
// ============================================================================
module div32_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    localparam logic [1:0] c_stIdle = 2'd0;
    localparam logic [1:0] c_stRun  = 2'd1;
    localparam logic [1:0] c_stFin  = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;      // partial remainder R
    logic [WIDTH-1:0] r_quo;      // working quotient Q, starts as the dividend
    logic [WIDTH-1:0] r_divisor;

    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_nextRem;
    logic [WIDTH-1:0] w_nextQuo;
    logic             w_accept;

    // The trial value is one bit wider than R so a set MSB of R is never lost.
    // When T >= divisor the difference is below the divisor, so WIDTH bits
    // suffice to hold it.
    assign w_trial   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_trial >= {1'b0, r_divisor});
    assign w_diff    = w_trial[WIDTH-1:0] - r_divisor;
    assign w_nextRem = w_ge ? w_diff : w_trial[WIDTH-1:0];
    assign w_nextQuo = {r_quo[WIDTH-2:0], w_ge};

    // A request is only honoured when no division is in flight.
    assign w_accept  = start && (r_state != c_stRun);

    assign busy = (r_state == c_stRun);
    assign done = (r_state == c_stFin);

    // Control FSM plus datapath: accept, one restoring step per clock, result load.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= c_stIdle;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
        end else begin
            case (r_state)
                c_stIdle, c_stFin: begin
                    if (w_accept) begin
                        r_divisor <= divisor;
                        r_quo     <= dividend;
                        r_rem     <= '0;
                        divByZero <= (divisor == '0);
                        // A zero divisor spends a single RUN cycle so its
                        // result appears with a latency of one.
                        r_count   <= (divisor == '0) ? '0 : CW'(WIDTH - 1);
                        r_state   <= c_stRun;
                    end else begin
                        r_state   <= c_stIdle;
                    end
                end
                c_stRun: begin
                    if (divByZero) begin
                        // r_quo still holds the untouched dividend here.
                        quotient  <= '1;
                        remainder <= r_quo;
                        r_state   <= c_stFin;
                    end else begin
                        r_rem   <= w_nextRem;
                        r_quo   <= w_nextQuo;
                        r_count <= r_count - CW'(1);
                        if (r_count == '0) begin
                            quotient  <= w_nextQuo;
                            remainder <= w_nextRem;
                            r_state   <= c_stFin;
                        end
                    end
                end
                default: r_state <= c_stIdle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div32_seq
//  Purpose  : Self-checking bench for div32_seq against an arithmetic
//             reference model (/, % and the divide-by-zero rule).
//  Revision : 1.0  initial release
// ============================================================================
module tb_div32_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rstN;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;

    int nCmp = 0;
    int nErr = 0;

    logic [WIDTH-1:0] lastQ;
    logic [WIDTH-1:0] lastR;
    logic             lastDz;

    div32_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one division (called #1 after a rising edge), optionally poking a
    // second start at RUN cycle pokeAt, and check timing and results. Returns
    // in the done cycle so the next call can start back-to-back.
    task automatic doOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int pokeAt, input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb);
        logic [WIDTH-1:0] eq, er;
        logic             edz;
        int               lat, n;
        logic             gotDone;
        if (b == '0) begin
            eq = '1; er = a; edz = 1'b1; lat = 1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; lat = WIDTH;
        end
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        n = 0; gotDone = 1'b0;
        while (!gotDone && n <= lat + 4) begin
            if (n == pokeAt) begin
                start = 1'b1; dividend = pa; divisor = pb;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done) begin
                gotDone = 1'b1;
            end else begin
                checkEq("busyRun", {63'd0, busy}, 64'd1);
                checkEq("holdRun", {quotient, remainder}, {lastQ, lastR});
            end
        end
        checkEq("doneSeen", {63'd0, gotDone}, 64'd1);
        checkEq("latency", 64'(n), 64'(lat));
        checkEq("busyDone", {63'd0, busy}, 64'd0);
        checkEq("quotient", {32'd0, quotient}, {32'd0, eq});
        checkEq("remainder", {32'd0, remainder}, {32'd0, er});
        checkEq("divByZero", {63'd0, divByZero}, {63'd0, edz});
        lastQ = eq; lastR = er; lastDz = edz;
    endtask

    // One idle cycle after done: pulse must end and results must hold.
    task automatic idleCheck();
        @(posedge clk); #1;
        checkEq("donePulse", {63'd0, done}, 64'd0);
        checkEq("busyIdle", {63'd0, busy}, 64'd0);
        checkEq("holdIdle", {31'd0, divByZero, quotient}, {31'd0, lastDz, lastQ});
    endtask

    initial begin
        logic [WIDTH-1:0] a, b;
        logic             seen;
        int               sel;

        rstN = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        lastQ = '0; lastR = '0; lastDz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkEq("rstBusy", {63'd0, busy}, 64'd0);
        checkEq("rstDone", {63'd0, done}, 64'd0);
        checkEq("rstOut", {31'd0, divByZero, quotient, remainder}, 64'd0);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        doOp(32'd100, 32'd7, -1, '0, '0);          idleCheck();
        doOp(32'hFFFFFFFF, 32'd1, -1, '0, '0);     idleCheck();
        doOp(32'hFFFFFFFF, 32'hFFFFFFFF, -1, '0, '0); idleCheck();
        doOp(32'd3, 32'd10, -1, '0, '0);           idleCheck();
        doOp(32'd5, 32'd0, -1, '0, '0);            idleCheck();
        doOp(32'd9, 32'd3, -1, '0, '0);            idleCheck();

        // Start during RUN is ignored; then a back-to-back start in the done cycle
        doOp(32'd1000, 32'd10, 5, 32'd7, 32'd2);
        doOp(32'd7, 32'd2, -1, '0, '0);            idleCheck();

        // Asynchronous reset in the middle of an operation
        start = 1'b1; dividend = 32'd50; divisor = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkEq("asyncBusy", {63'd0, busy}, 64'd0);
        checkEq("asyncOut", {31'd0, divByZero, quotient, remainder}, 64'd0);
        lastQ = '0; lastR = '0; lastDz = 1'b0;
        seen = done;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | done;
        end
        rstN = 1'b1;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            seen = seen | done;
        end
        checkEq("noDoneAfterRst", {63'd0, seen}, 64'd0);
        doOp(32'd50, 32'd4, -1, '0, '0);           idleCheck();

        // Randomized operands, mixing back-to-back and idle-gap issue
        for (int i = 0; i < 1400; i++) begin
            sel = $urandom_range(0, 7);
            a = $urandom;
            case (sel)
                0: b = '0;
                1: b = 32'd1;
                2: b = a;
                3: b = 32'($urandom_range(1, 15));
                4: b = $urandom | 32'h8000_0000;
                5: begin a = 32'($urandom_range(0, 255)); b = $urandom >> $urandom_range(0, 31); end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            doOp(a, b, -1, '0, '0);
            if ($urandom_range(0, 1) == 1) idleCheck();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
